// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES     = 4;
    localparam int unsigned PC_ALIGN_BITS   = 2;
    localparam int unsigned DEF_ADDR_WIDTH  = 32;
    localparam int unsigned DEF_INSTR_WIDTH = 32;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  pc;
        logic [DEF_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // FIFO operation per cycle, encoded {pop, push}. Flush outranks both;
    // a push into a full FIFO is only legal as OP_BOTH.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush and full-with-pop push rule.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned AW    = DEF_ADDR_WIDTH,
    parameter int unsigned IW    = DEF_INSTR_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_pop_req,
    input  logic [AW-1:0]            i_push_pc,
    input  logic [IW-1:0]            i_push_instr,
    output logic                     o_push,
    output logic                     o_pop,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [AW-1:0]            o_head_pc,
    output logic [IW-1:0]            o_head_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_push;
    logic            w_valid;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & i_pop_req & ~i_flush;
    assign w_push  = ~i_flush & ((r_count < FULL_COUNT) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            case (fifo_op(w_push, w_pop))
                OP_PUSH: r_count <= r_count + 1'b1;
                OP_POP:  r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{pc: i_push_pc, instr: i_push_instr};
    end

    assign o_push       = w_push;
    assign o_pop        = w_pop;
    assign o_valid      = w_valid;
    assign o_full       = (r_count == FULL_COUNT);
    assign o_count      = r_count;
    assign o_head_pc    = w_valid ? r_mem[r_rd_ptr].pc    : '0;
    assign o_head_instr = w_valid ? r_mem[r_rd_ptr].instr : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, redirect handling and prefetch queue towards decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter int unsigned            FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDR_WIDTH-1:0]    A_Instr,
    input  logic [INSTR_WIDTH-1:0]   Instr,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDR_WIDTH-1:0]    out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stall
`endif
);

    logic [ADDR_WIDTH-1:0]          r_fetch_pc;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_full;
    logic [$clog2(FIFO_DEPTH):0]    w_count;

    fetch_fifo #(
        .AW    (ADDR_WIDTH),
        .IW    (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (redirect_valid),
        .i_pop_req    (out_ready),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (Instr),
        .o_push       (w_push),
        .o_pop        (w_pop),
        .o_valid      (out_valid),
        .o_full       (w_full),
        .o_count      (w_count),
        .o_head_pc    (out_pc),
        .o_head_instr (out_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[ADDR_WIDTH-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
    end

    assign A_Instr = r_fetch_pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_unused_count;

    assign w_unused_count = ^w_count;

    // Counters survive redirects; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push)          r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_full & ~w_pop) r_perf_stall   <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    logic w_unused_perf;
    assign w_unused_perf = ^{w_count, w_full, w_pop};
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit; define FETCH_PERF_CNT_EN to also check counters.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A_Instr;
    logic [31:0] Instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (4),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .A_Instr        (A_Instr),
        .Instr          (Instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    assign Instr = mem_word(A_Instr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;
    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = 32'h0;
        m_fetched = 32'h0;
        m_stall   = 32'h0;
    endtask

    // One cycle: drive inputs at negedge, compare against the model, advance the model.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        bit pop;
        bit push;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("a_instr", A_Instr, m_pc);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", out_instr, q[0].instr);
        end else begin
            check("out_pc_empty", out_pc, 32'h0);
            check("out_instr_empty", out_instr, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall", perf_stall, m_stall);
`endif
        pop  = (q.size() != 0) && rdy && !rv;
        push = !rv && (q.size() < 4 || pop);
        if (q.size() == 4 && !pop) m_stall++;
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{m_pc, mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                m_fetched++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();

        // Reset held
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_instr", A_Instr, 32'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming at one instruction per cycle
        repeat (8) step(1'b1, 1'b0, 32'h0);

        // Stall from reset until full, then drain with no bubble
        do_reset();
        repeat (8) step(1'b0, 1'b0, 32'h0);
        check("stall_a_instr", A_Instr, 32'h10);
        check("stall_head_pc", out_pc, 32'h0);
        repeat (7) step(1'b1, 1'b0, 32'h0);

        // Redirect with three queued entries and out_ready high
        step(1'b0, 1'b1, 32'h100);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h43);
        repeat (5) step(1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: last one wins
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 32'h303);
        repeat (4) step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset mid-stream with two entries queued
        step(1'b0, 1'b1, 32'h500);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_a_instr", A_Instr, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step(1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
